// File: rtl/butterfly_pkg.sv
// Shared types and constants for the butterfly front-end sequencer.
//
// Contents:
//   ctrl_state_t : sequencer states. The numeric value of each state is
//                  shown directly on the board's state LEDs.
//   ERR_DISPLAY  : word shown on the display while the sequencer is in ERROR.
//   WORD_W       : default operand/result word width.
//   word_t       : one operand/result word of WORD_W bits.
package butterfly_pkg;

    localparam int WORD_W = 8;

    typedef logic [WORD_W-1:0] word_t;

    localparam logic [7:0] ERR_DISPLAY = 8'hEE;

    // The encodings follow the order in which the states are visited.
    // The LED code for a state is its position in that sequence.
    typedef enum logic [3:0] {
        LD_TW     = 4'd0,
        LD_BRE    = 4'd1,
        LD_BIM    = 4'd2,
        LD_ARE    = 4'd3,
        LD_AIM    = 4'd4,
        START     = 4'd5,
        WAIT_DONE = 4'd6,
        SHOW_ARE  = 4'd7,
        SHOW_AIM  = 4'd8,
        SHOW_BRE  = 4'd9,
        SHOW_BIM  = 4'd10,
        ERROR     = 4'd11
    } ctrl_state_t;

endpackage

// File: rtl/switch_debounce.sv
// Conditions one raw, bouncy board switch.
//
// The module synchronises the switch, debounces it, and raises a one-cycle
// step pulse when the debounced level falls from 1 to 0.
//
// Parameters:
//   DEBOUNCE_CYCLES : number of cycles the synchronised level must stay
//                     stable before the debounced level accepts it.
//
// Ports:
//   Clock  in  : system clock. All logic runs on the rising edge.
//   nReset in  : asynchronous active-low reset.
//   raw    in  : raw switch input. It is asynchronous to Clock.
//   step   out : one-cycle pulse on a debounced 1->0 transition.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic Clock,
    input  logic nReset,
    input  logic raw,
    output logic step
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] count;

    // Two-flop synchroniser feeds a stability counter.
    //
    // The counter runs only while the synchronised value disagrees with the
    // accepted level. Any agreement throws the partial count away. On reaching
    // the limit, the new level is taken and the counter clears, so it never
    // wraps.
    //
    // Everything resets high, so a switch that is resting high at power-up
    // produces no event.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            level  <= 1'b1;
            count  <= '0;
            step   <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            step   <= 1'b0;
            if (sync_b == level) begin
                count <= '0;
            end else if (count == CNT_MAX) begin
                level <= sync_b;
                count <= '0;
                step  <= ~sync_b;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/butterfly_ctrl.sv
// Front-end sequencer for the radix-2 butterfly core.
//
// Step presses on the control switch load the twiddle index and the four
// operand words from the slide switches. After the last load, the sequencer
// fires one start pulse at the core and waits, with a timeout, for the core's
// done flag. It then steps the four result words onto the display, one word
// per press.
//
// Parameters:
//   DEBOUNCE_CYCLES : stability time of the control switch, in clock cycles.
//   TIMEOUT_CYCLES  : maximum number of cycles spent waiting for core_done.
//   DATA_W          : operand/result word width.
//
// Ports:
//   Clock, nReset                       : clock; asynchronous active-low reset.
//   sswitch                             : operand slide switches (quasi-static).
//   control                             : raw step switch.
//   core_done                           : core completion pulse.
//   res_are, res_aim, res_bre, res_bim  : core results, valid with core_done.
//   twiddle_idx                         : latched twiddle index.
//   op_bre, op_bim, op_are, op_aim      : latched operands driven to the core.
//   core_start                          : one-cycle start pulse to the core.
//   display                             : word currently shown.
//   state_leds                          : encoded current state.
//   error                               : high while the sequencer is in ERROR.
module butterfly_ctrl
    import butterfly_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int DATA_W          = 8
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [DATA_W-1:0] sswitch,
    input  logic              control,
    input  logic              core_done,
    input  logic [DATA_W-1:0] res_are,
    input  logic [DATA_W-1:0] res_aim,
    input  logic [DATA_W-1:0] res_bre,
    input  logic [DATA_W-1:0] res_bim,
    output logic [2:0]        twiddle_idx,
    output logic [DATA_W-1:0] op_bre,
    output logic [DATA_W-1:0] op_bim,
    output logic [DATA_W-1:0] op_are,
    output logic [DATA_W-1:0] op_aim,
    output logic              core_start,
    output logic [DATA_W-1:0] display,
    output logic [3:0]        state_leds,
    output logic              error
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_t       state;
    logic              step;
    logic [TO_W-1:0]   timeout_count;
    logic [DATA_W-1:0] cap_are;
    logic [DATA_W-1:0] cap_aim;
    logic [DATA_W-1:0] cap_bre;
    logic [DATA_W-1:0] cap_bim;

    // Control switch conditioning: debounced falling edge becomes a step.
    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_control_debounce (
        .Clock (Clock),
        .nReset(nReset),
        .raw   (control),
        .step  (step)
    );

    assign state_leds = state;

    // Main sequencer.
    //
    // core_start, error and display are registered alongside the state. They
    // are set on the edge that enters a state, so core_start is high exactly
    // while the state is START, and error is high exactly while it is ERROR.
    //
    // A core_done seen outside WAIT_DONE is ignored, so the captured results
    // only change on a real completion. In WAIT_DONE the case arms give
    // core_done priority over the timeout, and steps are not looked at there.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state         <= LD_TW;
            twiddle_idx   <= '0;
            op_bre        <= '0;
            op_bim        <= '0;
            op_are        <= '0;
            op_aim        <= '0;
            cap_are       <= '0;
            cap_aim       <= '0;
            cap_bre       <= '0;
            cap_bim       <= '0;
            display       <= '0;
            core_start    <= 1'b0;
            error         <= 1'b0;
            timeout_count <= '0;
        end else begin
            case (state)
                LD_TW: begin
                    if (step) begin
                        twiddle_idx <= sswitch[2:0];
                        state       <= LD_BRE;
                    end
                end
                LD_BRE: begin
                    if (step) begin
                        op_bre <= sswitch;
                        state  <= LD_BIM;
                    end
                end
                LD_BIM: begin
                    if (step) begin
                        op_bim <= sswitch;
                        state  <= LD_ARE;
                    end
                end
                LD_ARE: begin
                    if (step) begin
                        op_are <= sswitch;
                        state  <= LD_AIM;
                    end
                end
                LD_AIM: begin
                    if (step) begin
                        op_aim     <= sswitch;
                        core_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    core_start    <= 1'b0;
                    timeout_count <= '0;
                    state         <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (core_done) begin
                        cap_are <= res_are;
                        cap_aim <= res_aim;
                        cap_bre <= res_bre;
                        cap_bim <= res_bim;
                        display <= res_are;
                        state   <= SHOW_ARE;
                    end else if (timeout_count == TO_MAX) begin
                        error   <= 1'b1;
                        display <= DATA_W'(ERR_DISPLAY);
                        state   <= ERROR;
                    end else begin
                        timeout_count <= timeout_count + 1'b1;
                    end
                end
                SHOW_ARE: begin
                    if (step) begin
                        display <= cap_aim;
                        state   <= SHOW_AIM;
                    end
                end
                SHOW_AIM: begin
                    if (step) begin
                        display <= cap_bre;
                        state   <= SHOW_BRE;
                    end
                end
                SHOW_BRE: begin
                    if (step) begin
                        display <= cap_bim;
                        state   <= SHOW_BIM;
                    end
                end
                SHOW_BIM: begin
                    if (step) begin
                        state <= LD_TW;
                    end
                end
                ERROR: begin
                    if (step) begin
                        error <= 1'b0;
                        state <= LD_TW;
                    end
                end
                default: begin
                    core_start <= 1'b0;
                    error      <= 1'b0;
                    state      <= LD_TW;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_butterfly_ctrl.sv
// Directed self-checking bench for butterfly_ctrl.
//
// The bench runs the design with a short debounce time and a short timeout.
// It loads operands through debounced presses, then checks the start pulse,
// result capture and display stepping, the timeout into ERROR, and an
// asynchronous reset taken mid-run.
module tb_butterfly_ctrl;

    localparam int ST_LD_TW     = 0;
    localparam int ST_LD_BRE    = 1;
    localparam int ST_LD_ARE    = 3;
    localparam int ST_START     = 5;
    localparam int ST_WAIT_DONE = 6;
    localparam int ST_SHOW_ARE  = 7;

    logic       clock = 1'b0;
    logic       nReset;
    logic [7:0] sswitch;
    logic       control;
    logic       coreDone;
    logic [7:0] resAre, resAim, resBre, resBim;
    logic [2:0] twiddleIdx;
    logic [7:0] opBre, opBim, opAre, opAim;
    logic       coreStart;
    logic [7:0] display;
    logic [3:0] stateLeds;
    logic       error;

    int checkCount = 0;
    int failCount  = 0;
    int startPulses = 0;

    // Free-running clock with a 10 ns period.
    always #5 clock = ~clock;

    butterfly_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (16),
        .DATA_W         (8)
    ) dut (
        .Clock      (clock),
        .nReset     (nReset),
        .sswitch    (sswitch),
        .control    (control),
        .core_done  (coreDone),
        .res_are    (resAre),
        .res_aim    (resAim),
        .res_bre    (resBre),
        .res_bim    (resBim),
        .twiddle_idx(twiddleIdx),
        .op_bre     (opBre),
        .op_bim     (opBim),
        .op_are     (opAre),
        .op_aim     (opAim),
        .core_start (coreStart),
        .display    (display),
        .state_leds (stateLeds),
        .error      (error)
    );

    // Counts the cycles in which the start pulse is high, sampled on the
    // falling edge so the value is settled.
    always @(negedge clock) begin
        if (coreStart) startPulses++;
    end

    // Compares one observed value against its expected value and reports
    // any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One clean press: the switch is held low, then released high. Each
    // phase is long enough for the debouncer to settle.
    task automatic applyStimulus(input logic [7:0] sw);
        sswitch = sw;
        control = 1'b0;
        waitCycles(10);
        control = 1'b1;
        waitCycles(10);
    endtask

    // Press that should launch the core.
    //
    // The task returns on the falling edge at which core_start is seen high.
    // The switch is released right away, so the release settles while the
    // sequencer waits for the core.
    task automatic pressToStart(input logic [7:0] sw);
        bit seen;
        seen = 1'b0;
        sswitch = sw;
        control = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (coreStart) seen = 1'b1;
        end
        control = 1'b1;
        checkOutput("start_seen", {31'd0, seen}, 32'd1);
    endtask

    // Safety net: the run always ends, even if a wait stalls.
    initial begin
        #1000000;
        failCount++;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    initial begin
        int lat;
        int n;
        nReset   = 1'b0;
        control  = 1'b1;
        sswitch  = 8'h00;
        coreDone = 1'b0;
        resAre = 8'h00; resAim = 8'h00; resBre = 8'h00; resBim = 8'h00;
        waitCycles(3);
        nReset = 1'b1;
        waitCycles(20);

        // Reset state, with the switch resting high.
        checkOutput("reset_state", {28'd0, stateLeds}, ST_LD_TW);
        checkOutput("reset_twiddle", {29'd0, twiddleIdx}, 32'd0);
        checkOutput("reset_op_bre", {24'd0, opBre}, 32'd0);
        checkOutput("reset_op_aim", {24'd0, opAim}, 32'd0);
        checkOutput("reset_start", {31'd0, coreStart}, 32'd0);
        checkOutput("reset_display", {24'd0, display}, 32'd0);
        checkOutput("reset_error", {31'd0, error}, 32'd0);

        // Two-cycle bounces must not produce a step.
        sswitch = 8'h05;
        control = 1'b0; waitCycles(2);
        control = 1'b1; waitCycles(2);
        control = 1'b0; waitCycles(2);
        control = 1'b1; waitCycles(2);
        checkOutput("bounce_no_step", {28'd0, stateLeds}, ST_LD_TW);

        // Expected latency from settling low to the visible state change:
        //   2 cycles through the synchroniser,
        //   4 cycles of debounce count (including the accepting edge),
        //   1 cycle for the state register.
        // This gives 7 falling edges after the drive.
        control = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            lat++;
            if (stateLeds != 4'(ST_LD_TW)) break;
        end
        checkOutput("step_latency", lat, 32'd7);
        checkOutput("tw_state", {28'd0, stateLeds}, ST_LD_BRE);
        checkOutput("tw_value", {29'd0, twiddleIdx}, 32'd5);
        waitCycles(10);
        checkOutput("single_step", {28'd0, stateLeds}, ST_LD_BRE);

        // Release with a bounce: the rising edge gives no step.
        control = 1'b1; waitCycles(2);
        control = 1'b0; waitCycles(2);
        control = 1'b1; waitCycles(12);
        checkOutput("rise_no_step", {28'd0, stateLeds}, ST_LD_BRE);

        // Operand loading, start pulse and result display.
        applyStimulus(8'h10);
        checkOutput("op_bre", {24'd0, opBre}, 32'h10);
        applyStimulus(8'h20);
        checkOutput("op_bim", {24'd0, opBim}, 32'h20);
        applyStimulus(8'h30);
        checkOutput("op_are", {24'd0, opAre}, 32'h30);
        startPulses = 0;
        pressToStart(8'h40);
        checkOutput("op_aim", {24'd0, opAim}, 32'h40);
        checkOutput("start_state", {28'd0, stateLeds}, ST_START);
        waitCycles(1);
        checkOutput("start_dropped", {31'd0, coreStart}, 32'd0);
        checkOutput("wait_state", {28'd0, stateLeds}, ST_WAIT_DONE);
        waitCycles(1);
        coreDone = 1'b1;
        resAre = 8'h11; resAim = 8'h22; resBre = 8'h33; resBim = 8'h44;
        waitCycles(1);
        coreDone = 1'b0;
        checkOutput("show_are_state", {28'd0, stateLeds}, ST_SHOW_ARE);
        checkOutput("show_are", {24'd0, display}, 32'h11);
        checkOutput("start_width", startPulses, 32'd1);
        resAre = 8'h00; resAim = 8'h00; resBre = 8'h00; resBim = 8'h00;
        waitCycles(10);
        applyStimulus(8'h00);
        checkOutput("show_aim", {24'd0, display}, 32'h22);
        applyStimulus(8'h00);
        checkOutput("show_bre", {24'd0, display}, 32'h33);
        applyStimulus(8'h00);
        checkOutput("show_bim", {24'd0, display}, 32'h44);
        applyStimulus(8'h00);
        checkOutput("show_return", {28'd0, stateLeds}, ST_LD_TW);
        checkOutput("show_keep_display", {24'd0, display}, 32'h44);

        // Timeout path.
        // WAIT_DONE lasts 16 cycles, so error appears 17 falling edges after
        // the START cycle.
        applyStimulus(8'h02);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        pressToStart(8'h04);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            n++;
            if (error) break;
        end
        checkOutput("timeout_cycles", n, 32'd17);
        checkOutput("error_flag", {31'd0, error}, 32'd1);
        checkOutput("error_display", {24'd0, display}, 32'hEE);
        applyStimulus(8'h00);
        checkOutput("error_exit_state", {28'd0, stateLeds}, ST_LD_TW);
        checkOutput("error_cleared", {31'd0, error}, 32'd0);
        checkOutput("operand_kept", {24'd0, opAim}, 32'h04);

        // Asynchronous reset while waiting for the core.
        applyStimulus(8'h03);
        applyStimulus(8'h0B);
        applyStimulus(8'h0C);
        applyStimulus(8'h0D);
        pressToStart(8'h0E);
        waitCycles(1);
        checkOutput("pre_reset_wait", {28'd0, stateLeds}, ST_WAIT_DONE);
        #1 nReset = 1'b0;
        #1;
        checkOutput("async_state", {28'd0, stateLeds}, ST_LD_TW);
        checkOutput("async_twiddle", {29'd0, twiddleIdx}, 32'd0);
        checkOutput("async_op_bre", {24'd0, opBre}, 32'd0);
        checkOutput("async_op_aim", {24'd0, opAim}, 32'd0);
        checkOutput("async_start", {31'd0, coreStart}, 32'd0);
        waitCycles(2);
        nReset = 1'b1;
        waitCycles(10);

        // A stray done in LD_ARE must be ignored.
        applyStimulus(8'h01);
        applyStimulus(8'h21);
        applyStimulus(8'h22);
        checkOutput("ld_are_state", {28'd0, stateLeds}, ST_LD_ARE);
        coreDone = 1'b1;
        resAre = 8'h99; resAim = 8'h99; resBre = 8'h99; resBim = 8'h99;
        waitCycles(1);
        coreDone = 1'b0;
        waitCycles(2);
        checkOutput("stray_done_state", {28'd0, stateLeds}, ST_LD_ARE);
        checkOutput("stray_done_display", {24'd0, display}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
